// File: rtl/multicycle_controller.sv
// Phase sequencer for the multi-cycle RV32I datapath: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and gates memory handshakes and datapath strobes per phase.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  input  logic       stall,
  output logic       imem_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       dmem_req,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ALUsrc,
  output logic       branch,
  output logic       RegWrite,
  output logic [1:0] ALUop,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    StFetch  = 3'b000,
    StDecode = 3'b001,
    StExec   = 3'b010,
    StMem    = 3'b011,
    StWb     = 3'b100,
    StTrap   = 3'b111
  } state_e;

  typedef enum logic [3:0] {
    ClsNone, ClsR, ClsIalu, ClsLoad, ClsJalr, ClsStore,
    ClsBr, ClsLui, ClsAuipc, ClsJal, ClsIllegal
  } cls_e;

  state_e          r_state;
  cls_e            r_cls;
  logic [CntW-1:0] r_cnt;
  logic            r_illegal;
  logic            r_timeout;

  cls_e            w_dec_cls;
  logic            w_mem_last;

  always_comb begin
    case (opcode)
      7'b0110011: w_dec_cls = ClsR;
      7'b0010011: w_dec_cls = ClsIalu;
      7'b0000011: w_dec_cls = ClsLoad;
      7'b1100111: w_dec_cls = ClsJalr;
      7'b0100011: w_dec_cls = ClsStore;
      7'b1100011: w_dec_cls = ClsBr;
      7'b0110111: w_dec_cls = ClsLui;
      7'b0010111: w_dec_cls = ClsAuipc;
      7'b1101111: w_dec_cls = ClsJal;
      default:    w_dec_cls = ClsIllegal;
    endcase
  end

  assign w_mem_last = (r_cnt == CntW'(MEM_TIMEOUT - 1));

  // Stall freezes state and the wait counter; TRAP never leaves anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StFetch;
      r_cls     <= ClsNone;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else if (!stall) begin
      case (r_state)
        StFetch: begin
          r_cls <= ClsNone;
          if (imem_ack) r_state <= StDecode;
        end
        StDecode: begin
          r_cls <= w_dec_cls;
          if (w_dec_cls == ClsIllegal) begin
            r_illegal <= 1'b1;
            r_state   <= StTrap;
          end else begin
            r_state <= StExec;
          end
        end
        StExec: begin
          r_cnt <= '0;
          case (r_cls)
            ClsBr:             r_state <= StFetch;
            ClsLoad, ClsStore: r_state <= StMem;
            default:           r_state <= StWb;
          endcase
        end
        StMem: begin
          if (dmem_ack) begin
            r_cnt   <= '0;
            r_state <= (r_cls == ClsLoad) ? StWb : StFetch;
          end else if (w_mem_last) begin
            r_cnt     <= '0;
            r_timeout <= 1'b1;
            r_state   <= StTrap;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWb:    r_state <= StFetch;
        StTrap:  r_state <= StTrap;
        default: r_state <= StTrap;
      endcase
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal;
  assign timeout = r_timeout;

  // Strobes are held low for the whole time rst is high, not just after the edge.
  always_comb begin
    imem_req = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    dmem_req = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUsrc   = 1'b0;
    branch   = 1'b0;
    RegWrite = 1'b0;
    ALUop    = 2'b00;
    if (!rst) begin
      case (r_state)
        StFetch: begin
          imem_req = !stall;
          ir_write = imem_ack && !stall;
        end
        StExec: begin
          ALUsrc = !(r_cls == ClsR || r_cls == ClsBr);
          if (r_cls == ClsR || r_cls == ClsIalu) ALUop = 2'b10;
          else if (r_cls == ClsBr)               ALUop = 2'b01;
          if (r_cls == ClsBr) begin
            branch   = !stall;
            pc_write = !stall;
          end
        end
        StMem: begin
          dmem_req = !stall;
          MemRead  = (r_cls == ClsLoad);
          MemWrite = (r_cls == ClsStore);
          ALUsrc   = 1'b1;
          pc_write = (r_cls == ClsStore) && dmem_ack && !stall;
        end
        StWb: begin
          RegWrite = !stall;
          pc_write = !stall;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction phase-list model checked every
// cycle, plus hand-computed literal expectations on state and key strobes.
module tb_multicycle_controller;

  localparam int unsigned MEM_TIMEOUT = 16;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_X     = 7'b1110011;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       imem_ack, dmem_ack, stall;
  logic       imem_req, ir_write, pc_write, dmem_req, MemRead, MemWrite;
  logic       ALUsrc, branch, RegWrite, illegal, timeout;
  logic [1:0] ALUop;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .stall(stall), .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
    .dmem_req(dmem_req), .MemRead(MemRead), .MemWrite(MemWrite), .ALUsrc(ALUsrc),
    .branch(branch), .RegWrite(RegWrite), .ALUop(ALUop), .state(state),
    .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Model: phase numbers are the documented state codes; each class has a phase list.
  int         m_ph;
  int         m_wait;
  logic [6:0] m_op;
  logic       m_ill, m_to;

  function automatic bit legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_L, OP_JALR, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL};
  endfunction

  function automatic int next_ph(input logic [6:0] op, input int ph);
    int seq[5];
    int n;
    seq = '{0, 1, 2, 4, 0};
    n = 4;
    if (op == OP_L)      begin seq = '{0, 1, 2, 3, 4}; n = 5; end
    else if (op == OP_S) begin seq = '{0, 1, 2, 3, 0}; n = 4; end
    else if (op == OP_B) begin seq = '{0, 1, 2, 0, 0}; n = 3; end
    next_ph = 0;
    for (int k = 0; k < n - 1; k++) if (seq[k] == ph) next_ph = seq[k + 1];
  endfunction

  function automatic logic [15:0] exp_vec(input int ph, input logic [6:0] op,
                                          input logic ia, da, st, r, ill, to);
    logic iq, iw, pw, dq, mr, mw, as, br, rw;
    logic [1:0] ao;
    bit is_exec, is_mem, is_wb, isb, iss;
    if (r) return 16'h0000;
    is_exec = (ph == 2);
    is_mem  = (ph == 3);
    is_wb   = (ph == 4);
    isb     = (op == OP_B);
    iss     = (op == OP_S);
    iq = (ph == 0) && !st;
    iw = (ph == 0) && ia && !st;
    pw = !st && ((is_exec && isb) || (is_mem && iss && da) || is_wb);
    dq = is_mem && !st;
    mr = is_mem && (op == OP_L);
    mw = is_mem && iss;
    as = (is_exec && !(op == OP_R || isb)) || is_mem;
    br = is_exec && isb && !st;
    rw = is_wb && !st;
    ao = 2'b00;
    if (is_exec && (op == OP_R || op == OP_I)) ao = 2'b10;
    else if (is_exec && isb)                   ao = 2'b01;
    return {iq, iw, pw, dq, mr, mw, as, br, rw, ao, 3'(ph), ill, to};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph   <= 0;
      m_op   <= '0;
      m_wait <= 0;
      m_ill  <= 1'b0;
      m_to   <= 1'b0;
    end else if (m_ph != 7 && !stall) begin
      case (m_ph)
        0: if (imem_ack) m_ph <= 1;
        1: begin
          m_op <= opcode;
          if (legal(opcode)) m_ph <= next_ph(opcode, 1);
          else begin
            m_ph  <= 7;
            m_ill <= 1'b1;
          end
        end
        3: begin
          if (dmem_ack) begin
            m_wait <= 0;
            m_ph   <= next_ph(m_op, 3);
          end else if (m_wait == MEM_TIMEOUT - 1) begin
            m_to <= 1'b1;
            m_ph <= 7;
          end else begin
            m_wait <= m_wait + 1;
          end
        end
        default: m_ph <= next_ph(m_op, m_ph);
      endcase
    end
  end

  logic [15:0] w_dut;
  assign w_dut = {imem_req, ir_write, pc_write, dmem_req, MemRead, MemWrite, ALUsrc, branch,
                  RegWrite, ALUop, state, illegal, timeout};

  always @(negedge clk) begin
    logic [15:0] e;
    e = exp_vec(m_ph, m_op, imem_ack, dmem_ack, stall, rst, m_ill, m_to);
    n_checks++;
    if (w_dut !== e) begin
      n_fail++;
      $display("FAIL cycle_outputs t=%0t actual=%04h required=%04h", $time, w_dut, e);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic setc(input logic [6:0] op, input logic ia, da, st, input logic [2:0] es);
    opcode   = op;
    imem_ack = ia;
    dmem_ack = da;
    stall    = st;
    #1;
    chk("state", 16'(state), 16'(es));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [6:0] op, input logic ia, da, st, input logic [2:0] es);
    setc(op, ia, da, st, es);
    nxt();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    opcode = '0; imem_ack = 1'b0; dmem_ack = 1'b0; stall = 1'b0;
    #1;
    chk("rst_outputs", w_dut, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // R-type, zero-wait: 000,001,010,100 then back to 000.
    step(OP_R, 1, 0, 0, 3'b000);
    step(OP_R, 0, 0, 0, 3'b001);
    setc(OP_R, 0, 0, 0, 3'b010);
    chk("r_aluop", 16'(ALUop), 16'h2);
    chk("r_regw_exec", 16'(RegWrite), 16'h0);
    nxt();
    setc(OP_R, 0, 0, 0, 3'b100);
    chk("r_regw_wb", 16'(RegWrite), 16'h1);
    nxt();

    // LOAD with three wait cycles in MEM.
    step(OP_L, 1, 0, 0, 3'b000);
    step(OP_L, 0, 0, 0, 3'b001);
    step(OP_L, 0, 0, 0, 3'b010);
    for (int i = 0; i < 3; i++) begin
      setc(OP_L, 0, 0, 0, 3'b011);
      chk("ld_dmem_req", 16'({dmem_req, MemRead}), 16'h3);
      nxt();
    end
    setc(OP_L, 0, 1, 0, 3'b011);
    chk("ld_ack_memread", 16'(MemRead), 16'h1);
    nxt();
    setc(OP_L, 0, 0, 0, 3'b100);
    chk("ld_wb_regw", 16'(RegWrite), 16'h1);
    nxt();

    // Branch stalled for two EXEC cycles.
    step(OP_B, 1, 0, 0, 3'b000);
    step(OP_B, 0, 0, 0, 3'b001);
    for (int i = 0; i < 2; i++) begin
      setc(OP_B, 0, 0, 1, 3'b010);
      chk("br_stalled", 16'({branch, pc_write}), 16'h0);
      chk("br_aluop_held", 16'(ALUop), 16'h1);
      nxt();
    end
    setc(OP_B, 0, 0, 0, 3'b010);
    chk("br_pulse", 16'({branch, pc_write}), 16'h3);
    nxt();

    // Stall on the fetch ack cycle delays the transition; IALU follows.
    setc(OP_I, 1, 0, 1, 3'b000);
    chk("fetch_stall", 16'({imem_req, ir_write}), 16'h0);
    nxt();
    step(OP_I, 1, 0, 0, 3'b000);
    step(OP_I, 0, 0, 0, 3'b001);
    step(OP_I, 0, 0, 0, 3'b010);
    step(OP_I, 0, 0, 0, 3'b100);

    // LUI: immediate operand, add.
    step(OP_LUI, 1, 0, 0, 3'b000);
    step(OP_LUI, 0, 0, 0, 3'b001);
    setc(OP_LUI, 0, 0, 0, 3'b010);
    chk("lui_exec", 16'({ALUsrc, ALUop}), 16'h4);
    nxt();
    step(OP_LUI, 0, 0, 0, 3'b100);

    // JAL/JALR/AUIPC all take the four-cycle path.
    step(OP_JAL, 1, 0, 0, 3'b000);
    step(OP_JAL, 0, 0, 0, 3'b001);
    step(OP_JAL, 0, 0, 0, 3'b010);
    step(OP_JAL, 0, 0, 0, 3'b100);
    step(OP_JALR, 1, 0, 0, 3'b000);
    step(OP_JALR, 0, 0, 0, 3'b001);
    step(OP_JALR, 0, 0, 0, 3'b010);
    step(OP_JALR, 0, 0, 0, 3'b100);
    step(OP_AUIPC, 1, 0, 0, 3'b000);
    step(OP_AUIPC, 0, 0, 0, 3'b001);
    step(OP_AUIPC, 0, 0, 0, 3'b010);
    step(OP_AUIPC, 0, 0, 0, 3'b100);

    // STORE: ack on the last allowed wait cycle wins over the timeout; one stall mid-MEM.
    step(OP_S, 1, 0, 0, 3'b000);
    step(OP_S, 0, 0, 0, 3'b001);
    step(OP_S, 0, 0, 0, 3'b010);
    for (int i = 0; i < 14; i++) step(OP_S, 0, 0, 0, 3'b011);
    setc(OP_S, 0, 1, 1, 3'b011);
    chk("st_stall_mem", 16'({dmem_req, MemWrite, pc_write}), 16'h2);
    nxt();
    step(OP_S, 0, 0, 0, 3'b011);
    setc(OP_S, 0, 1, 0, 3'b011);
    chk("st_ack_pcw", 16'(pc_write), 16'h1);
    nxt();
    setc(OP_S, 0, 0, 0, 3'b000);
    chk("st_no_timeout", 16'(timeout), 16'h0);
    nxt();

    // Asynchronous reset in the middle of a LOAD's MEM phase.
    step(OP_L, 1, 0, 0, 3'b000);
    step(OP_L, 0, 0, 0, 3'b001);
    step(OP_L, 0, 0, 0, 3'b010);
    setc(OP_L, 0, 0, 0, 3'b011);
    chk("pre_rst_dmem_req", 16'(dmem_req), 16'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst", 16'({dmem_req, MemRead, state}), 16'h0);
    nxt();
    rst = 1'b0;
    step(OP_R, 1, 0, 0, 3'b000);
    step(OP_R, 0, 0, 0, 3'b001);
    step(OP_R, 0, 0, 0, 3'b010);
    step(OP_R, 0, 0, 0, 3'b100);

    // Illegal opcode traps from DECODE and stays there.
    step(OP_X, 1, 0, 0, 3'b000);
    setc(OP_X, 0, 0, 0, 3'b001);
    chk("ill_before", 16'(illegal), 16'h0);
    nxt();
    setc(OP_X, 0, 0, 0, 3'b111);
    chk("ill_set", 16'({illegal, RegWrite, MemWrite, pc_write}), 16'h8);
    nxt();
    step(OP_X, 1, 1, 0, 3'b111);
    step(OP_X, 1, 1, 1, 3'b111);
    do_reset();

    // STORE that never gets an ack: TRAP after the sixteenth MEM cycle.
    step(OP_S, 1, 0, 0, 3'b000);
    step(OP_S, 0, 0, 0, 3'b001);
    step(OP_S, 0, 0, 0, 3'b010);
    for (int i = 0; i < 16; i++) begin
      setc(OP_S, 0, 0, 0, 3'b011);
      chk("to_memwrite", 16'({MemWrite, timeout}), 16'h2);
      nxt();
    end
    setc(OP_S, 0, 0, 0, 3'b111);
    chk("to_trap", 16'({timeout, MemWrite, dmem_req}), 16'h4);
    nxt();
    step(OP_S, 1, 1, 0, 3'b111);
    step(OP_S, 1, 1, 0, 3'b111);
    do_reset();
    step(OP_R, 1, 0, 0, 3'b000);
    step(OP_R, 0, 0, 0, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
